// File: rtl/pe_carry_resolve.sv
// pe_carry_resolve
// Consumer end of the PE column-sum stream. Column accumulators arrive least
// significant first; each one is added to the running carry, the low K bits
// leave as a normalized digit, and the rest stays as carry. After the last
// column, the residual carry is flushed as N_EXT extra digits.
// The output is a single registered slot with a valid/ready handshake.
module pe_carry_resolve #(
  parameter  int K       = 16,
  parameter  int N_WORDS = 16,
  parameter  int ACC_W   = 48,
  localparam int CW      = ACC_W + 1 - K,
  localparam int N_EXT   = (CW + K - 1) / K,
  localparam int N_DIG   = N_WORDS + N_EXT,
  localparam int IDX_W   = $clog2(N_DIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [ACC_W-1:0] i_s,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [K-1:0]     o_d,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    carry_q;
  logic [IDX_W-1:0] cnt_q;     // index of the next digit to be loaded
  logic             o_valid_q;
  logic [K-1:0]     o_d_q;
  logic [IDX_W-1:0] o_idx_q;
  logic             o_last_q;
  logic             o_busy_q;

  logic [ACC_W:0]   sum_s;
  logic             slot_free_s;
  logic             in_ready_s;
  logic             in_xfer_s;

  // Column sum plus carry at full width, and input handshake qualification.
  always_comb begin
    sum_s       = {1'b0, i_s} + {{K{1'b0}}, carry_q};
    slot_free_s = !o_valid_q || o_ready;
    if (state_q == FLUSH) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = slot_free_s;
    end
    in_xfer_s = i_valid && in_ready_s;
  end

  // Frame FSM with carry register, digit counter and the registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      carry_q   <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_d_q     <= '0;
      o_idx_q   <= '0;
      o_last_q  <= 1'b0;
      o_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (in_xfer_s) begin
            o_valid_q <= 1'b1;
            o_d_q     <= sum_s[K-1:0];
            o_idx_q   <= cnt_q;
            o_last_q  <= 1'b0;
            carry_q   <= sum_s[ACC_W:K];
            cnt_q     <= cnt_q + IDX_W'(1);
            o_busy_q  <= 1'b1;
            if (cnt_q == IDX_W'(N_WORDS - 1)) begin
              state_q <= FLUSH;
            end else begin
              state_q <= RUN;
            end
          end else if (o_ready) begin
            o_valid_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (slot_free_s) begin
            o_valid_q <= 1'b1;
            o_d_q     <= carry_q[K-1:0];
            o_idx_q   <= cnt_q;
            if (cnt_q == IDX_W'(N_DIG - 1)) begin
              // Last flush digit: the carry is exhausted, ready for a new frame.
              o_last_q <= 1'b1;
              carry_q  <= '0;
              cnt_q    <= '0;
              state_q  <= IDLE;
              o_busy_q <= 1'b0;
            end else begin
              o_last_q <= 1'b0;
              carry_q  <= carry_q >> K;
              cnt_q    <= cnt_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          carry_q   <= '0;
          cnt_q     <= '0;
          o_valid_q <= 1'b0;
          o_last_q  <= 1'b0;
          o_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready = in_ready_s;
  assign o_valid = o_valid_q;
  assign o_d     = o_d_q;
  assign o_idx   = o_idx_q;
  assign o_last  = o_last_q;
  assign o_busy  = o_busy_q;

endmodule
